// File: rtl/uc_pkg.sv
// Shared opcode constants and control-FSM state type for the microc control unit.
package uc_pkg;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_LI   = 6'b000001;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JZ   = 6'b000011;
  localparam logic [5:0] OP_JNZ  = 6'b000100;
  localparam logic [5:0] OP_CALL = 6'b000101;
  localparam logic [5:0] OP_RET  = 6'b000110;
  localparam logic [5:0] OP_HALT = 6'b000111;
  localparam logic [2:0] OP_ALU  = 3'b001;

  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Pushing while full and popping while empty are silently dropped.
module ret_stack #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0][PC_W-1:0] mem;
  logic [SP_W-1:0]            sp;
  logic [SP_W-1:0]            sp_m1;

  assign full  = (sp == SP_W'(DEPTH));
  assign empty = (sp == '0);
  assign sp_m1 = sp - SP_W'(1);
  assign top   = empty ? '0 : mem[sp_m1[IDX_W-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp  <= '0;
      mem <= '0;
    end else if (push && !full) begin
      mem[sp[IDX_W-1:0]] <= din;
      sp                 <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp_m1;
    end
  end

endmodule

// File: rtl/uc_stack.sv
// Control unit for the single-cycle microc datapath: opcode decode, call/ret stack,
// halt, and a sticky fault on stack overflow/underflow.
module uc_stack
  import uc_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      opcode,
  input  logic            z,
  input  logic [PC_W-1:0] pc_cur,
  output logic            s_inc,
  output logic            s_ret,
  output logic [PC_W-1:0] ret_addr,
  output logic            pc_we,
  output logic            s_inm,
  output logic            we3,
  output logic            wez,
  output logic [2:0]      op,
  output logic            halted,
  output logic            stack_err,
  output logic            illegal
);

  state_t state, nxt;
  logic   push, pop, full, empty;

  ret_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) u_stk (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_cur + PC_W'(1)),
    .top   (ret_addr),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= nxt;
  end

  assign op        = opcode[2:0];
  assign illegal   = (opcode[5:4] != 2'b00);
  assign halted    = (state == HALT);
  assign stack_err = (state == FAULT);

  always_comb begin
    s_inc = 1'b0;
    s_ret = 1'b0;
    pc_we = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    nxt   = state;
    if (opcode[5:3] == OP_ALU) begin
      s_inc = 1'b1;
      we3   = 1'b1;
      wez   = 1'b1;
    end else begin
      case (opcode)
        OP_NOP: s_inc = 1'b1;
        OP_LI: begin
          s_inc = 1'b1;
          s_inm = 1'b1;
          we3   = 1'b1;
        end
        OP_J:   s_inc = 1'b0;
        OP_JZ:  s_inc = ~z;
        OP_JNZ: s_inc = z;
        OP_CALL: begin
          if (full) begin
            pc_we = 1'b0;
            nxt   = FAULT;
          end else begin
            push = 1'b1;
          end
        end
        OP_RET: begin
          if (empty) begin
            pc_we = 1'b0;
            nxt   = FAULT;
          end else begin
            s_ret = 1'b1;
            pop   = 1'b1;
          end
        end
        OP_HALT: begin
          pc_we = 1'b0;
          nxt   = HALT;
        end
        default: s_inc = 1'b1;
      endcase
    end
    // HALT and FAULT freeze the PC, register file, flags and stack until reset.
    if (state != RUN) begin
      pc_we = 1'b0;
      we3   = 1'b0;
      wez   = 1'b0;
      s_ret = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
      nxt   = state;
    end
  end

endmodule

// File: tb/tb_uc_stack.sv
// Scoreboard bench for uc_stack: the driver queues hand-computed expectations,
// a monitor on the falling edge pops and compares them against the outputs.
module tb_uc_stack;
  import uc_pkg::*;

  localparam int PC_W  = 10;
  localparam int DEPTH = 4;
  localparam int X     = -1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [5:0]      opcode = '0;
  logic            z = 1'b0;
  logic [PC_W-1:0] pc_cur = '0;
  logic            s_inc, s_ret, pc_we, s_inm, we3, wez, halted, stack_err, illegal;
  logic [PC_W-1:0] ret_addr;
  logic [2:0]      op;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string nm;
    int si, sr, pw, sm, w3, wz, hl, se, il, o, ra;
  } exp_t;

  exp_t q[$];

  uc_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .z         (z),
    .pc_cur    (pc_cur),
    .s_inc     (s_inc),
    .s_ret     (s_ret),
    .ret_addr  (ret_addr),
    .pc_we     (pc_we),
    .s_inm     (s_inm),
    .we3       (we3),
    .wez       (wez),
    .op        (op),
    .halted    (halted),
    .stack_err (stack_err),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string f, input int act, input int exp);
    if (exp >= 0) begin
      checks++;
      if (act != exp) begin
        errors++;
        $display("FAIL %s.%s: got %0d expected %0d", nm, f, act, exp);
      end
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "s_inc",     int'(s_inc),     e.si);
      chk(e.nm, "s_ret",     int'(s_ret),     e.sr);
      chk(e.nm, "pc_we",     int'(pc_we),     e.pw);
      chk(e.nm, "s_inm",     int'(s_inm),     e.sm);
      chk(e.nm, "we3",       int'(we3),       e.w3);
      chk(e.nm, "wez",       int'(wez),       e.wz);
      chk(e.nm, "halted",    int'(halted),    e.hl);
      chk(e.nm, "stack_err", int'(stack_err), e.se);
      chk(e.nm, "illegal",   int'(illegal),   e.il);
      chk(e.nm, "op",        int'(op),        e.o);
      chk(e.nm, "ret_addr",  int'(ret_addr),  e.ra);
    end
  end

  task automatic drive(input string nm, input logic rv, input logic [5:0] opc, input logic zz,
                       input int pc, input int si, input int sr, input int pw, input int sm,
                       input int w3, input int wz, input int hl, input int se, input int il,
                       input int ra);
    exp_t e;
    @(posedge clk);
    #1;
    reset  = rv;
    opcode = opc;
    z      = zz;
    pc_cur = PC_W'(pc);
    e = '{nm, si, sr, pw, sm, w3, wz, hl, se, il, int'(opc[2:0]), ra};
    q.push_back(e);
  endtask

  initial begin
    logic [5:0] hold_ops [5];
    hold_ops = '{OP_NOP, OP_LI, 6'b001011, OP_RET, OP_CALL};

    //      name        rst opcode      z  pc      si sr pw sm w3 wz hl se il ra
    drive("rst",        0, OP_NOP,     0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive("nop",        1, OP_NOP,     0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive("li",         1, OP_LI,      0, 0,      1, 0, 1, 1, 1, 0, 0, 0, 0, X);
    drive("alu_add",    1, 6'b001010,  0, 0,      1, 0, 1, 0, 1, 1, 0, 0, 0, X);
    drive("jz_z1",      1, OP_JZ,      1, 0,      0, 0, 1, 0, 0, 0, X, X, 0, X);
    drive("jz_z0",      1, OP_JZ,      0, 0,      1, 0, 1, 0, 0, 0, X, X, 0, X);
    drive("jnz_z0",     1, OP_JNZ,     0, 0,      0, 0, 1, 0, 0, 0, X, X, 0, X);
    drive("j",          1, OP_J,       1, 0,      0, 0, 1, 0, 0, 0, X, X, 0, X);
    drive("call5",      1, OP_CALL,    0, 'h005,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive("call20",     1, OP_CALL,    0, 'h020,  0, 0, 1, 0, 0, 0, 0, 0, 0, 'h006);
    drive("ret1",       1, OP_RET,     0, 0,      0, 1, 1, 0, 0, 0, 0, 0, 0, 'h021);
    drive("ret2",       1, OP_RET,     0, 0,      0, 1, 1, 0, 0, 0, 0, 0, 0, 'h006);
    drive("empty",      1, OP_NOP,     0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < DEPTH; i++)
      drive($sformatf("fill%0d", i), 1, OP_CALL, 0, 'h100 + i,
            0, 0, 1, 0, 0, 0, 0, 0, 0, (i == 0) ? 0 : 'h100 + i);
    drive("overflow",   1, OP_CALL,    0, 'h104,  0, 0, 0, 0, 0, 0, 0, 0, 0, 'h104);
    drive("flt_nop",    1, OP_NOP,     0, 0,      X, 0, 0, X, 0, 0, 0, 1, 0, 'h104);
    drive("flt_li",     1, OP_LI,      0, 0,      X, 0, 0, X, 0, 0, 0, 1, 0, 'h104);
    drive("flt_alu",    1, 6'b001111,  0, 0,      X, 0, 0, X, 0, 0, 0, 1, 0, 'h104);
    drive("flt_ret",    1, OP_RET,     0, 0,      X, 0, 0, X, 0, 0, 0, 1, 0, 'h104);
    drive("flt_ill",    1, 6'b111111,  0, 0,      X, 0, 0, X, 0, 0, 0, 1, 1, 'h104);
    drive("rst_flt",    0, OP_NOP,     0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    drive("underflow",  1, OP_RET,     0, 0,      X, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("unf_flt",    1, OP_NOP,     0, 0,      X, 0, 0, X, 0, 0, 0, 1, 0, 0);
    drive("rst_unf",    0, OP_NOP,     0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    drive("halt",       1, OP_HALT,    0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      drive($sformatf("halted%0d", i), 1, hold_ops[i % 5], 0, 'h050,
            X, 0, 0, X, 0, 0, 1, 0, 0, 0);
    drive("rst_halt",   0, OP_NOP,     0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    drive("ill_3f",     1, 6'b111111,  0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    drive("ill_10",     1, 6'b010000,  0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    drive("call30",     1, OP_CALL,    0, 'h030,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive("pre_rst",    1, OP_NOP,     0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 'h031);
    drive("mid_rst",    0, OP_CALL,    0, 'h035,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive("call40",     1, OP_CALL,    0, 'h040,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive("ret40",      1, OP_RET,     0, 0,      0, 1, 1, 0, 0, 0, 0, 0, 0, 'h041);
    drive("empty2",     1, OP_NOP,     0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
